// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between two req/gnt/rvalid hosts.
//   Host 0 is instruction fetch and host 1 is data. Ties go to the current owner
//   until it has held the RAM for MaxBurst consecutive grants, then to the other host.
//   Read responses return one cycle after the grant and go to the host that issued them.
// Parameters:
//   Aw       SRAM word-address width
//   Dw       data and bit-mask width
//   MaxBurst consecutive grants to one host while the other waits (1..255)
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   hN_req_i / hN_gnt_o           per-host request and same-cycle accept
//   hN_we_i, hN_addr_i,
//   hN_wdata_i, hN_wmask_i        per-host access attributes
//   hN_rdata_o / hN_rvalid_o      per-host read response
//   ram_*_o / ram_*_i             single-port SRAM macro port
//   stall_clr_i / stall_cnt_o     clear / saturating count of cycles with a refused host
//   err_o                         sticky: SRAM read valid seen with no read outstanding
module sram_arbiter #(
  parameter int unsigned Aw       = 12,
  parameter int unsigned Dw       = 32,
  parameter int unsigned MaxBurst = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          h0_req_i,
  output logic          h0_gnt_o,
  input  logic          h0_we_i,
  input  logic [Aw-1:0] h0_addr_i,
  input  logic [Dw-1:0] h0_wdata_i,
  input  logic [Dw-1:0] h0_wmask_i,
  output logic [Dw-1:0] h0_rdata_o,
  output logic          h0_rvalid_o,

  input  logic          h1_req_i,
  output logic          h1_gnt_o,
  input  logic          h1_we_i,
  input  logic [Aw-1:0] h1_addr_i,
  input  logic [Dw-1:0] h1_wdata_i,
  input  logic [Dw-1:0] h1_wmask_i,
  output logic [Dw-1:0] h1_rdata_o,
  output logic          h1_rvalid_o,

  output logic          ram_req_o,
  output logic          ram_we_o,
  output logic [Aw-1:0] ram_addr_o,
  output logic [Dw-1:0] ram_wdata_o,
  output logic [Dw-1:0] ram_wmask_o,
  input  logic [Dw-1:0] ram_rdata_i,
  input  logic          ram_rvalid_i,

  input  logic          stall_clr_i,
  output logic [15:0]   stall_cnt_o,
  output logic          err_o
);

  localparam logic [7:0] MaxBurstW = 8'(MaxBurst);

  logic        owner_q, owner_d;
  logic [7:0]  burst_q, burst_d;
  logic        rd_pend_q;
  logic        rd_host_q;
  logic        rst_recover_q;
  logic [15:0] stall_q;
  logic        err_q;

  logic        tie_keep;
  logic        gnt0, gnt1;
  logic        refused;

  // Grant decision. A zero burst count only exists straight out of reset and means
  // nobody holds the RAM yet, so the tie goes to the non-owner (host 0).
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    tie_keep = (burst_q != 8'd0) && (burst_q < MaxBurstW);
    if (rst_ni) begin
      case ({h1_req_i, h0_req_i})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          if (tie_keep) begin
            gnt0 = ~owner_q;
            gnt1 = owner_q;
          end else begin
            gnt0 = owner_q;
            gnt1 = ~owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM request mux; zeros when idle.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (gnt0) begin
      ram_we_o    = h0_we_i;
      ram_addr_o  = h0_addr_i;
      ram_wdata_o = h0_wdata_i;
      ram_wmask_o = h0_wmask_i;
    end else if (gnt1) begin
      ram_we_o    = h1_we_i;
      ram_addr_o  = h1_addr_i;
      ram_wdata_o = h1_wdata_i;
      ram_wmask_o = h1_wmask_i;
    end
  end

  // Ownership and burst tracking. The granted host index equals gnt1.
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (gnt0 || gnt1) begin
      if (gnt1 == owner_q) begin
        burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
      end else begin
        owner_d = gnt1;
        burst_d = 8'd1;
      end
    end
  end

  assign refused = (h0_req_i & ~gnt0) | (h1_req_i & ~gnt1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q       <= 1'b1;
      burst_q       <= 8'd0;
      rd_pend_q     <= 1'b0;
      rd_host_q     <= 1'b0;
      rst_recover_q <= 1'b1;
      stall_q       <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      burst_q       <= burst_d;
      rd_pend_q     <= (gnt0 | gnt1) & ~ram_we_o;
      rd_host_q     <= gnt1;
      rst_recover_q <= 1'b0;
      if (stall_clr_i) begin
        stall_q <= 16'd0;
      end else if (refused && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      // A valid left over from a read dropped by reset is not an error.
      if (ram_rvalid_i && !rd_pend_q && !rst_recover_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign h0_gnt_o    = gnt0;
  assign h1_gnt_o    = gnt1;
  assign ram_req_o   = gnt0 | gnt1;
  assign h0_rvalid_o = rst_ni & ram_rvalid_i & rd_pend_q & ~rd_host_q;
  assign h1_rvalid_o = rst_ni & ram_rvalid_i & rd_pend_q & rd_host_q;
  assign h0_rdata_o  = ram_rdata_i;
  assign h1_rdata_o  = ram_rdata_i;
  assign stall_cnt_o = stall_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a behavioural SRAM, a reference model of the
// arbitration rules, a constant table for the contention pattern and directed corner cases.
module tb_sram_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        rst_n;
  logic        h0_req, h1_req, h0_we, h1_we;
  logic [11:0] h0_addr, h1_addr;
  logic [31:0] h0_wdata, h1_wdata, h0_wmask, h1_wmask;
  logic        h0_gnt, h1_gnt, h0_rvalid, h1_rvalid;
  logic [31:0] h0_rdata, h1_rdata;
  logic        ram_req, ram_we, ram_rvalid;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_wmask, ram_rdata;
  logic        stall_clr;
  logic [15:0] stall_cnt;
  logic        err;
  logic        force_rv;

  sram_arbiter #(.Aw(12), .Dw(32), .MaxBurst(MAXB)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .h0_req_i    (h0_req),
    .h0_gnt_o    (h0_gnt),
    .h0_we_i     (h0_we),
    .h0_addr_i   (h0_addr),
    .h0_wdata_i  (h0_wdata),
    .h0_wmask_i  (h0_wmask),
    .h0_rdata_o  (h0_rdata),
    .h0_rvalid_o (h0_rvalid),
    .h1_req_i    (h1_req),
    .h1_gnt_o    (h1_gnt),
    .h1_we_i     (h1_we),
    .h1_addr_i   (h1_addr),
    .h1_wdata_i  (h1_wdata),
    .h1_wmask_i  (h1_wmask),
    .h1_rdata_o  (h1_rdata),
    .h1_rvalid_o (h1_rvalid),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_wmask_o (ram_wmask),
    .ram_rdata_i (ram_rdata),
    .ram_rvalid_i(ram_rvalid),
    .stall_clr_i (stall_clr),
    .stall_cnt_o (stall_cnt),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [31:0] sram_mem [4096];
  logic        sram_rv;
  logic [31:0] sram_rdata;
  always @(posedge clk) begin
    sram_rv <= 1'b0;
    if (ram_req && !ram_we) begin
      sram_rv    <= 1'b1;
      sram_rdata <= sram_mem[ram_addr];
    end
    if (ram_req && ram_we) begin
      sram_mem[ram_addr] <= (sram_mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end
  assign ram_rvalid = sram_rv | force_rv;
  assign ram_rdata  = sram_rdata;

  // Reference model state.
  logic [31:0] ref_mem [4096];
  int          m_last, m_streak;
  bit          m_pend;
  int          m_host;
  logic [31:0] m_rdata;
  int          m_stall;
  bit          m_err, m_after;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Host that should win this cycle, -1 if none.
  function automatic int pick();
    if (!rst_n || (!h0_req && !h1_req)) return -1;
    if (h0_req && !h1_req) return 0;
    if (h1_req && !h0_req) return 1;
    if (m_streak > 0 && m_streak < MAXB) return m_last;
    return 1 - m_last;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit do_chk);
    int          g;
    bit          rv_in, refused, e0, e1;
    logic        we;
    logic [11:0] a;
    logic [31:0] wd, wm;
    @(negedge clk);
    g     = pick();
    rv_in = ram_rvalid;
    we = 1'b0; a = '0; wd = '0; wm = '0;
    if (g == 0) begin
      we = h0_we; a = h0_addr; wd = h0_wdata; wm = h0_wmask;
    end else if (g == 1) begin
      we = h1_we; a = h1_addr; wd = h1_wdata; wm = h1_wmask;
    end
    e0 = rst_n && rv_in && m_pend && (m_host == 0);
    e1 = rst_n && rv_in && m_pend && (m_host == 1);
    if (do_chk) begin
      chk("h0_gnt", 32'(h0_gnt), 32'(g == 0));
      chk("h1_gnt", 32'(h1_gnt), 32'(g == 1));
      chk("ram_req", 32'(ram_req), 32'(g >= 0));
      chk("ram_we", 32'(ram_we), 32'(we));
      chk("ram_addr", 32'(ram_addr), 32'(a));
      chk("ram_wdata", ram_wdata, wd);
      chk("ram_wmask", ram_wmask, wm);
      chk("h0_rvalid", 32'(h0_rvalid), 32'(e0));
      chk("h1_rvalid", 32'(h1_rvalid), 32'(e1));
      if (e0) chk("h0_rdata", h0_rdata, m_rdata);
      if (e1) chk("h1_rdata", h1_rdata, m_rdata);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("err", 32'(err), 32'(m_err));
    end
    refused = (h0_req && g != 0) || (h1_req && g != 1);
    @(posedge clk);
    if (!rst_n) begin
      m_last = 1; m_streak = 0; m_pend = 0; m_stall = 0; m_err = 0; m_after = 1;
    end else begin
      if (rv_in && !m_pend && !m_after) m_err = 1;
      m_after = 0;
      if (stall_clr) m_stall = 0;
      else if (refused && m_stall < 16'hFFFF) m_stall++;
      m_pend = 0;
      if (g >= 0) begin
        if (g == m_last) m_streak = (m_streak < 255) ? m_streak + 1 : 255;
        else begin
          m_last = g; m_streak = 1;
        end
        if (we) begin
          ref_mem[a] = (ref_mem[a] & ~wm) | (wd & wm);
        end else begin
          m_pend = 1; m_host = g; m_rdata = ref_mem[a];
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    h0_req = 0; h1_req = 0; h0_we = 0; h1_we = 0;
  endtask

  typedef struct {
    bit          r0, r1;
    logic [11:0] a0, a1;
    bit          eg0, eg1;
  } vec_t;
  vec_t tbl[12];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
      ref_mem[i]  = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
    end
    for (int i = 0; i < 12; i++) begin
      tbl[i] = '{r0: 1'b1, r1: 1'b1, a0: 12'(i), a1: 12'(i + 64),
                 eg0: (i < 4 || i >= 8), eg1: (i >= 4 && i < 8)};
    end
    m_last = 1; m_streak = 0; m_pend = 0; m_host = 0; m_rdata = '0;
    m_stall = 0; m_err = 0; m_after = 1;
    rst_n = 0; force_rv = 0; stall_clr = 0;
    h0_addr = '0; h1_addr = '0; h0_wdata = '0; h1_wdata = '0;
    h0_wmask = '1; h1_wmask = '1;
    idle();
    @(posedge clk); #1;

    // Reset with both hosts requesting: everything quiet.
    h0_req = 1; h1_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_gnt0", 32'(h0_gnt), 0);
      chk("rst_gnt1", 32'(h1_gnt), 0);
      chk("rst_ram_req", 32'(ram_req), 0);
      step(1);
    end
    rst_n = 1;

    // Contention from reset: h0 x4, h1 x4, h0 x4.
    for (int i = 0; i < 12; i++) begin
      h0_req = tbl[i].r0; h1_req = tbl[i].r1;
      h0_addr = tbl[i].a0; h1_addr = tbl[i].a1;
      #1;
      chk("tbl_gnt0", 32'(h0_gnt), 32'(tbl[i].eg0));
      chk("tbl_gnt1", 32'(h1_gnt), 32'(tbl[i].eg1));
      step(1);
      if (i == 0) chk("stall_first", 32'(stall_cnt), 1);
    end
    chk("stall_contention", 32'(stall_cnt), 12);
    idle(); step(1);

    // Read routing.
    h1_req = 1; h1_we = 1; h1_addr = 12'h010; h1_wdata = 32'hDEADBEEF; h1_wmask = '1;
    step(1);
    idle(); h0_req = 1; h0_addr = 12'h010;
    step(1);
    idle(); h1_req = 1; h1_addr = 12'h020;
    #1;
    chk("route_h0_rv", 32'(h0_rvalid), 1);
    chk("route_h0_data", h0_rdata, 32'hDEADBEEF);
    step(1);
    idle();
    chk("route_h1_rv", 32'(h1_rvalid), 1);
    chk("route_h0_quiet", 32'(h0_rvalid), 0);
    step(1);

    // Masked write, no write response.
    h1_req = 1; h1_we = 1; h1_addr = 12'h030; h1_wdata = 32'hAAAAAAAA; h1_wmask = '1;
    step(1);
    h1_wdata = 32'h11223344; h1_wmask = 32'h0000FFFF;
    step(1);
    chk("wr_no_rv0", 32'(h0_rvalid), 0);
    chk("wr_no_rv1", 32'(h1_rvalid), 0);
    h1_we = 0;
    step(1);
    idle();
    chk("mask_rv", 32'(h1_rvalid), 1);
    chk("mask_data", h1_rdata, 32'hAAAA3344);
    step(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      h0_req = 1'($urandom); h1_req = 1'($urandom);
      h0_we = ($urandom_range(0, 2) == 0); h1_we = ($urandom_range(0, 2) == 0);
      h0_addr = 12'($urandom_range(0, 15)); h1_addr = 12'($urandom_range(0, 15));
      h0_wdata = $urandom; h1_wdata = $urandom;
      h0_wmask = $urandom; h1_wmask = $urandom;
      stall_clr = ($urandom_range(0, 15) == 0);
      step(1);
    end
    stall_clr = 0; idle(); step(1);

    // Reset in the middle of a read, then a spurious valid.
    h0_req = 1; h0_we = 0; h0_addr = 12'h005;
    step(1);
    idle(); rst_n = 0;
    step(1);
    rst_n = 1; force_rv = 1;
    step(1);
    force_rv = 0;
    chk("midrd_err", 32'(err), 0);
    step(1);
    force_rv = 1;
    step(1);
    force_rv = 0;
    chk("spurious_err", 32'(err), 1);
    for (int i = 0; i < 3; i++) step(1);
    chk("err_sticky", 32'(err), 1);

    // Saturation and clear.
    h0_req = 1; h1_req = 1;
    for (int i = 0; i < 70000; i++) step(0);
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    stall_clr = 1;
    step(1);
    chk("stall_clr", 32'(stall_cnt), 0);
    stall_clr = 0;
    step(1);
    chk("stall_after_clr", 32'(stall_cnt), 1);
    idle(); step(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
